iopad_triout_seq: RTL and testbench

- Parametrised, clocked successor to the single-channel tri-state output pad gate decoder.
- Drives NCH output pads; per channel, turns core data/enable/mode into pad-domain PMOS/NMOS gate controls.
- Enforces break-before-make dead time so both drivers are never on together.
- Supports push-pull, open-drain, open-source and forced hi-z modes.
- Sits between core logic and the level-shifted pad driver stage of each IO cell.

---
 rtl/iopad_triout_pkg.sv | 51 +++++
 rtl/iopad_gate_seq.sv | 139 +++++++++++++
 rtl/iopad_triout_seq.sv | 59 +++++
 tb/tb_iopad_triout_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iopad_triout_pkg.sv
// -----------------------------------------------------------------------------
// iopad_triout_pkg
//
// Shared definitions for the clocked tri-state output pad gate sequencer:
//   - per-channel mode encoding (MODE_PP / MODE_OD / MODE_OS / MODE_HIZ)
//   - per-channel drive state enum (OFF, HIGH, LOW, BREAK)
//   - target_decode(): combinational mapping of core inputs to the state
//     the channel wants to be in (never returns ST_BREAK)
// -----------------------------------------------------------------------------
package iopad_triout_pkg;

    // Per-channel mode field, two bits per channel on the top-level mode bus.
    localparam logic [1:0] MODE_PP  = 2'b00;  // push-pull
    localparam logic [1:0] MODE_OD  = 2'b01;  // open-drain (only pulls low)
    localparam logic [1:0] MODE_OS  = 2'b10;  // open-source (only pulls high)
    localparam logic [1:0] MODE_HIZ = 2'b11;  // forced hi-z

    // Channel drive state. ST_BREAK is the dead-time interval between a
    // high drive and a low drive (either direction); both gates are off.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_BREAK = 2'd3
    } gate_state_e;

    // Decode the core-side request into the drive state the channel should
    // settle in. kill and a deasserted enable override everything else.
    function automatic gate_state_e target_decode(
        input logic       c2p,
        input logic       en,
        input logic [1:0] mode,
        input logic       kill
    );
        gate_state_e t;
        t = ST_OFF;
        if (kill || !en) begin
            t = ST_OFF;
        end else begin
            case (mode)
                MODE_PP:  t = c2p ? ST_HIGH : ST_LOW;
                MODE_OD:  t = c2p ? ST_OFF  : ST_LOW;
                MODE_OS:  t = c2p ? ST_HIGH : ST_OFF;
                MODE_HIZ: t = ST_OFF;
                default:  t = ST_OFF;
            endcase
        end
        return t;
    endfunction

endpackage : iopad_triout_pkg

// File: rtl/iopad_gate_seq.sv
// -----------------------------------------------------------------------------
// iopad_gate_seq
//
// One pad channel: drive-state FSM plus dead-time counter. Converts the
// core request into PMOS (active-low) and NMOS (active-high) gate controls,
// inserting DEADTIME cycles with both drivers off on every reversal between
// high and low drive. Releasing the pad (target OFF) is never delayed.
//
// Ports:
//   clk_i     core clock
//   rst_ni    asynchronous active-low reset (channel OFF, gates released)
//   c2p_i     core data
//   en_i      core output enable
//   mode_i    channel mode (see iopad_triout_pkg MODE_*)
//   kill_i    synchronous global release
//   pgate_o   PMOS gate, 0 = drive pad high (registered)
//   ngate_o   NMOS gate, 1 = drive pad low (registered)
//   state_o   current drive state (registered), also the busy source
//
// Valid/ready: none. Inputs are sampled every rising edge; there is no
// handshake, the channel simply tracks its target subject to dead time.
// -----------------------------------------------------------------------------
module iopad_gate_seq
    import iopad_triout_pkg::*;
#(
    parameter int DEADTIME = 2   // 1..15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        c2p_i,
    input  logic        en_i,
    input  logic [1:0]  mode_i,
    input  logic        kill_i,
    output logic        pgate_o,
    output logic        ngate_o,
    output gate_state_e state_o
);

    localparam int            CW       = $clog2(DEADTIME + 1);
    // The cycle spent entering BREAK counts as the first dead cycle, so the
    // counter starts one short of DEADTIME and the exit happens when it
    // reads zero.
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEADTIME - 1);

    gate_state_e   target;
    gate_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pgate_q, pgate_d;
    logic          ngate_q, ngate_d;

    assign target = target_decode(c2p_i, en_i, mode_i, kill_i);

    // -------------------------------------------------------------------------
    // State register. Gate outputs are flops too, reset straight to the
    // released encoding so both drivers are off from the moment rst_ni falls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            pgate_q <= 1'b1;
            ngate_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pgate_q <= pgate_d;
            ngate_q <= ngate_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                // From OFF there is nothing to break: go straight to target.
                state_d = target;
            end
            ST_HIGH: begin
                if (target == ST_OFF) begin
                    state_d = ST_OFF;
                end else if (target == ST_LOW) begin
                    state_d = ST_BREAK;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_LOW: begin
                if (target == ST_OFF) begin
                    state_d = ST_OFF;
                end else if (target == ST_HIGH) begin
                    state_d = ST_BREAK;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BREAK: begin
                // Only a release can cut the dead time short. A target that
                // swings back to the original side still waits it out, which
                // keeps the guarantee independent of input history.
                if (target == ST_OFF) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = target;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, captured by the output flops so the
    // pad-side controls come straight from registers.
    // -------------------------------------------------------------------------
    always_comb begin
        pgate_d = 1'b1;
        ngate_d = 1'b0;
        case (state_d)
            ST_HIGH: pgate_d = 1'b0;
            ST_LOW:  ngate_d = 1'b1;
            default: begin
                pgate_d = 1'b1;
                ngate_d = 1'b0;
            end
        endcase
    end

    assign pgate_o = pgate_q;
    assign ngate_o = ngate_q;
    assign state_o = state_q;

endmodule : iopad_gate_seq

// File: rtl/iopad_triout_seq.sv
// -----------------------------------------------------------------------------
// iopad_triout_seq
//
// NCH-channel tri-state output pad gate sequencer. Each channel is an
// independent iopad_gate_seq with its own dead-time counter; nothing is
// shared between channels except clock, reset and the global kill.
//
// Ports:
//   clk      core clock
//   rst_n    asynchronous active-low reset
//   c2p      core data, one bit per channel
//   c2p_en   core output enable, one bit per channel
//   mode     two bits per channel, channel i at mode[2*i+1:2*i]
//   kill     synchronous global release, all channels off next edge
//   pgate    PMOS gate controls, active-low
//   ngate    NMOS gate controls, active-high
//   busy     channel is in its dead-time interval
// -----------------------------------------------------------------------------
module iopad_triout_seq
    import iopad_triout_pkg::*;
#(
    parameter int NCH      = 4,   // 1..32
    parameter int DEADTIME = 2    // 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   c2p,
    input  logic [NCH-1:0]   c2p_en,
    input  logic [2*NCH-1:0] mode,
    input  logic             kill,
    output logic [NCH-1:0]   pgate,
    output logic [NCH-1:0]   ngate,
    output logic [NCH-1:0]   busy
);

    // Per-channel drive state; a convenient probe point for checkers.
    gate_state_e ch_state [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        iopad_gate_seq #(
            .DEADTIME (DEADTIME)
        ) u_seq (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .c2p_i   (c2p[i]),
            .en_i    (c2p_en[i]),
            .mode_i  (mode[2*i +: 2]),
            .kill_i  (kill),
            .pgate_o (pgate[i]),
            .ngate_o (ngate[i]),
            .state_o (ch_state[i])
        );

        // busy is a pure decode of the state flop, so it carries no
        // combinational path from the core inputs.
        assign busy[i] = (ch_state[i] == ST_BREAK);
    end

endmodule : iopad_triout_seq

// File: tb/tb_iopad_triout_seq.sv
// -----------------------------------------------------------------------------
// tb_iopad_triout_seq
//
// Three DUT instances share the same stimulus: DEADTIME 3 (directed
// scenarios), 1 and 15 (extremes, exercised by the random run). A reference
// model based on absolute "dead time ends at cycle N" stamps tracks all
// three instances from the first clock.
// -----------------------------------------------------------------------------
module tb_iopad_triout_seq;

    localparam int NCH  = 4;
    localparam int NINS = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   c2p;
    logic [NCH-1:0]   c2p_en;
    logic [2*NCH-1:0] mode;
    logic             kill;

    logic [NCH-1:0]   pg_w [NINS];
    logic [NCH-1:0]   ng_w [NINS];
    logic [NCH-1:0]   bz_w [NINS];

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------ clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------------- DUTs
    iopad_triout_seq #(.NCH(NCH), .DEADTIME(3)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .c2p(c2p), .c2p_en(c2p_en), .mode(mode),
        .kill(kill), .pgate(pg_w[0]), .ngate(ng_w[0]), .busy(bz_w[0]));

    iopad_triout_seq #(.NCH(NCH), .DEADTIME(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .c2p(c2p), .c2p_en(c2p_en), .mode(mode),
        .kill(kill), .pgate(pg_w[1]), .ngate(ng_w[1]), .busy(bz_w[1]));

    iopad_triout_seq #(.NCH(NCH), .DEADTIME(15)) dut_d15 (
        .clk(clk), .rst_n(rst_n), .c2p(c2p), .c2p_en(c2p_en), .mode(mode),
        .kill(kill), .pgate(pg_w[2]), .ngate(ng_w[2]), .busy(bz_w[2]));

    function automatic int dt_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // -------------------------------------------------------- reference model
    // drive: 0 = pad released, 1 = driven high, 2 = driven low.
    // until: cycle number at which a pending dead time has fully elapsed.
    int drive_m [NINS][NCH];
    int until_m [NINS][NCH];
    bit busy_m  [NINS][NCH];
    int cyc = 0;

    // What the pad should do according to the current core inputs.
    function automatic int want(input int ch);
        int m;
        m = int'(mode[2*ch +: 2]);
        if (kill || !c2p_en[ch] || m == 3) return 0;
        if (m == 0) return c2p[ch] ? 1 : 2;
        if (m == 1) return c2p[ch] ? 0 : 2;
        return c2p[ch] ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NINS; k++)
            for (int ch = 0; ch < NCH; ch++) begin
                drive_m[k][ch] = 0;
                until_m[k][ch] = 0;
                busy_m[k][ch]  = 1'b0;
            end
    endtask

    task automatic model_edge();
        int t;
        for (int k = 0; k < NINS; k++)
            for (int ch = 0; ch < NCH; ch++) begin
                t = want(ch);
                if (t == 0) begin
                    drive_m[k][ch] = 0;
                    until_m[k][ch] = 0;
                    busy_m[k][ch]  = 1'b0;
                end else if (cyc < until_m[k][ch]) begin
                    busy_m[k][ch]  = 1'b1;
                end else if (drive_m[k][ch] != 0 && drive_m[k][ch] != t) begin
                    // Reversal: this cycle and the next DEADTIME-1 are dead.
                    drive_m[k][ch] = 0;
                    until_m[k][ch] = cyc + dt_of(k);
                    busy_m[k][ch]  = 1'b1;
                end else begin
                    drive_m[k][ch] = t;
                    busy_m[k][ch]  = 1'b0;
                end
            end
        cyc++;
    endtask

    function automatic logic [NCH-1:0] exp_pg(input int k);
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = (drive_m[k][ch] != 1);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_ng(input int k);
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = (drive_m[k][ch] == 2);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_bz(input int k);
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = busy_m[k][ch];
        return v;
    endfunction

    // ---------------------------------------------------------- driver tasks
    // One clock: advance the model with the inputs the DUT is about to
    // sample, then look at outputs 1 time unit after the edge.
    task automatic step();
        if (!rst_n) model_reset();
        else        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c2p    = '0;
        c2p_en = '0;
        mode   = '0;
        kill   = 1'b0;
        step();
        step();
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n  = 1'b1;
        c2p    = '0;
        c2p_en = '0;
        mode   = '0;
        kill   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NINS; k++) begin
            total++;
            if (pg_w[k] !== 4'hF || ng_w[k] !== 4'h0 || bz_w[k] !== 4'h0) begin
                bad++;
                $display("FAIL reset_entry inst%0d: pgate=%h ngate=%h busy=%h, want F 0 0",
                         k, pg_w[k], ng_w[k], bz_w[k]);
            end
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            for (int k = 0; k < NINS; k++) begin
                total++;
                if (pg_w[k] !== 4'hF || ng_w[k] !== 4'h0 || bz_w[k] !== 4'h0) begin
                    bad++;
                    $display("FAIL reset_idle inst%0d cyc%0d: pgate=%h ngate=%h busy=%h, want F 0 0",
                             k, i, pg_w[k], ng_w[k], bz_w[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        mode[1:0] = 2'b00;
        c2p[0]    = 1'b1;
        c2p_en[0] = 1'b1;
        step();
        step();
        total++;
        if (pg_w[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_pre: pgate[0]=%b, want 0", pg_w[0][0]);
        end
        // Assert reset between edges: outputs must release with no clock.
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NINS; k++) begin
            total++;
            if (pg_w[k] !== 4'hF || ng_w[k] !== 4'h0 || bz_w[k] !== 4'h0) begin
                bad++;
                $display("FAIL async_rst inst%0d: pgate=%h ngate=%h busy=%h, want F 0 0",
                         k, pg_w[k], ng_w[k], bz_w[k]);
            end
        end
        model_reset();
        #2 rst_n = 1'b1;
        step();
        total++;
        if (pg_w[0][0] !== 1'b0 || bz_w[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_exit: pgate[0]=%b busy[0]=%b, want 0 0",
                     pg_w[0][0], bz_w[0][0]);
        end
    endtask

    task automatic test_pp_reversal();
        idle_inputs();
        mode[1:0] = 2'b00;
        c2p_en[0] = 1'b1;
        c2p[0]    = 1'b1;
        step();
        total++;
        if (pg_w[0][0] !== 1'b0 || ng_w[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL pp_high: pgate[0]=%b ngate[0]=%b, want 0 0",
                     pg_w[0][0], ng_w[0][0]);
        end
        c2p[0] = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            total++;
            if (pg_w[0][0] !== 1'b1 || ng_w[0][0] !== (e >= 4) ||
                bz_w[0][0] !== (e <= 3)) begin
                bad++;
                $display("FAIL pp_reversal edge%0d: pgate=%b ngate=%b busy=%b, want 1 %0d %0d",
                         e, pg_w[0][0], ng_w[0][0], bz_w[0][0], e >= 4, e <= 3);
            end
        end
    endtask

    task automatic test_open_drain();
        logic exp_n;
        idle_inputs();
        mode[3:2] = 2'b01;
        c2p_en[1] = 1'b1;
        for (int seg = 0; seg < 3; seg++) begin
            c2p[1] = (seg == 1);
            exp_n  = (seg != 1);
            for (int i = 0; i < 5; i++) begin
                step();
                total++;
                if (ng_w[0][1] !== exp_n || pg_w[0][1] !== 1'b1 || bz_w[0][1] !== 1'b0) begin
                    bad++;
                    $display("FAIL open_drain seg%0d cyc%0d: ngate=%b pgate=%b busy=%b, want %b 1 0",
                             seg, i, ng_w[0][1], pg_w[0][1], bz_w[0][1], exp_n);
                end
            end
        end
    endtask

    task automatic test_break_flipback();
        idle_inputs();
        mode[5:4] = 2'b00;
        c2p_en[2] = 1'b1;
        c2p[2]    = 1'b1;
        step();
        step();
        c2p[2] = 1'b0;
        step();
        c2p[2] = 1'b1;   // back to the original side one cycle into BREAK
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) step();
            total++;
            if (bz_w[0][2] !== (e <= 3) || pg_w[0][2] !== (e <= 3) || ng_w[0][2] !== 1'b0) begin
                bad++;
                $display("FAIL flipback edge%0d: busy=%b pgate=%b ngate=%b, want %0d %0d 0",
                         e, bz_w[0][2], pg_w[0][2], ng_w[0][2], e <= 3, e <= 3);
            end
        end
    endtask

    task automatic test_kill();
        idle_inputs();
        c2p_en = 4'hF;
        mode   = '0;
        c2p    = 4'b0111;
        step();
        step();
        total++;
        if (pg_w[0] !== 4'b1000 || ng_w[0] !== 4'b1000) begin
            bad++;
            $display("FAIL kill_pre: pgate=%h ngate=%h, want 8 8", pg_w[0], ng_w[0]);
        end
        c2p[3] = 1'b1;
        step();
        total++;
        if (bz_w[0] !== 4'b1000) begin
            bad++;
            $display("FAIL kill_break: busy=%h, want 8", bz_w[0]);
        end
        kill = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int k = 0; k < NINS; k++) begin
                total++;
                if (pg_w[k] !== 4'hF || ng_w[k] !== 4'h0 || bz_w[k] !== 4'h0) begin
                    bad++;
                    $display("FAIL kill_active inst%0d cyc%0d: pgate=%h ngate=%h busy=%h, want F 0 0",
                             k, i, pg_w[k], ng_w[k], bz_w[k]);
                end
            end
        end
        // Release kill with channel 3 now asking for low: straight to LOW.
        c2p  = 4'b0111;
        kill = 1'b0;
        step();
        for (int k = 0; k < NINS; k++) begin
            total++;
            if (pg_w[k] !== 4'b1000 || ng_w[k] !== 4'b1000 || bz_w[k] !== 4'h0) begin
                bad++;
                $display("FAIL kill_release inst%0d: pgate=%h ngate=%h busy=%h, want 8 8 0",
                         k, pg_w[k], ng_w[k], bz_w[k]);
            end
        end
    endtask

    task automatic test_random();
        int run [NINS][NCH];
        for (int k = 0; k < NINS; k++)
            for (int ch = 0; ch < NCH; ch++) run[k][ch] = 0;
        c2p_en = 4'hF;
        kill   = 1'b0;
        for (int ch = 0; ch < NCH; ch++) mode[2*ch +: 2] = 2'($urandom_range(2));
        for (int n = 0; n < 10000; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(3) == 0)  c2p[ch]    = 1'($urandom_range(1));
                if ($urandom_range(63) == 0) c2p_en[ch] = ~c2p_en[ch];
                if ($urandom_range(63) == 0) mode[2*ch +: 2] = 2'($urandom_range(3));
            end
            kill = ($urandom_range(255) == 0);
            step();
            for (int k = 0; k < NINS; k++) begin
                total++;
                if ((~pg_w[k] & ng_w[k]) !== '0) begin
                    bad++;
                    $display("FAIL overlap inst%0d cyc%0d: pgate=%h ngate=%h",
                             k, n, pg_w[k], ng_w[k]);
                end
                total++;
                if (pg_w[k] !== exp_pg(k) || ng_w[k] !== exp_ng(k) || bz_w[k] !== exp_bz(k)) begin
                    bad++;
                    $display("FAIL random inst%0d cyc%0d: pgate=%h ngate=%h busy=%h, want %h %h %h",
                             k, n, pg_w[k], ng_w[k], bz_w[k], exp_pg(k), exp_ng(k), exp_bz(k));
                end
                // Dead-time length: busy run that ends in a drive must be
                // exactly DEADTIME long.
                for (int ch = 0; ch < NCH; ch++) begin
                    if (bz_w[k][ch] === 1'b1) begin
                        run[k][ch]++;
                    end else begin
                        if (run[k][ch] > 0 && (pg_w[k][ch] === 1'b0 || ng_w[k][ch] === 1'b1)) begin
                            total++;
                            if (run[k][ch] != dt_of(k)) begin
                                bad++;
                                $display("FAIL deadtime inst%0d ch%0d cyc%0d: length=%0d, want %0d",
                                         k, ch, n, run[k][ch], dt_of(k));
                            end
                        end
                        run[k][ch] = 0;
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        model_reset();
        test_reset();
        test_async_reset();
        test_pp_reversal();
        test_open_drain();
        test_break_flipback();
        test_kill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_iopad_triout_seq
